// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length enum, Nk/Nr/T lookups, xtime and S-box.
// AES_KEY_EXT_LEN_EN selects 60-word storage for 192/256-bit keys; otherwise 44 words.
package aes_pkg;

    typedef enum logic [1:0] {
        KLEN_128 = 2'b00,
        KLEN_192 = 2'b01,
        KLEN_256 = 2'b10,
        KLEN_BAD = 2'b11
    } key_len_e;

`ifdef AES_KEY_EXT_LEN_EN
    localparam int NW = 60;
`else
    localparam int NW = 44;
`endif

    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KLEN_192: return 4'd6;
            KLEN_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e len);
        case (len)
            KLEN_192: return 4'd12;
            KLEN_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] t_of(input key_len_e len);
        case (len)
            KLEN_192: return 6'd52;
            KLEN_256: return 6'd60;
            default:  return 6'd44;
        endcase
    endfunction

    // 0x80 naturally wraps to 0x1B through the reduction term.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational, no flow control.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub[31:24] = SBOX[word[31:24]];
    assign sub[23:16] = SBOX[word[23:16]];
    assign sub[15:8]  = SBOX[word[15:8]];
    assign sub[7:0]   = SBOX[word[7:0]];

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion, one word per non-stalled cycle; round-key reads have 1-cycle latency.
// stall_i freezes expansion; AES_KEY_EXT_LEN_EN adds 192/256-bit keys and err_o for illegal lengths.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int RD_PORTS = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [1:0]              key_len_i,
    input  logic [255:0]            key_i,
    input  logic                    stall_i,
    input  logic [4*RD_PORTS-1:0]   rd_idx_i,
    output logic [128*RD_PORTS-1:0] rd_key_o,
    output logic [RD_PORTS-1:0]     rd_valid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [3:0]              nr_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_e;

    state_e      state;
    logic [31:0] w [NW];
    logic [5:0]  i;          // number of words written so far
    logic [2:0]  j;          // i mod Nk, avoids a divider
    logic [7:0]  rcon;
    logic [3:0]  nk;
    logic [5:0]  t_words;
    key_len_e    len;
    logic        start_ok;

`ifdef AES_KEY_EXT_LEN_EN
    assign len      = key_len_e'(key_len_i);
    assign start_ok = start_i && (len != KLEN_BAD);
`else
    logic unused_ok;
    assign len       = KLEN_128;
    assign start_ok  = start_i;
    assign err_o     = 1'b0;
    assign unused_ok = ^{key_len_i, key_i[127:0]};
`endif

    logic [31:0] prev, sub_in, sub_out, temp, new_w;

    assign prev   = w[i - 6'd1];
    assign sub_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        temp = prev;
        if (j == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
`ifdef AES_KEY_EXT_LEN_EN
        else if (nk == 4'd8 && j == 3'd4)
            temp = sub_out;
`endif
        new_w = w[i - {2'b00, nk}] ^ temp;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            nr_o    <= 4'd0;
            i       <= 6'd0;
            j       <= 3'd0;
            rcon    <= 8'h01;
            nk      <= 4'd4;
            t_words <= 6'd44;
`ifdef AES_KEY_EXT_LEN_EN
            err_o   <= 1'b0;
`endif
        end else begin
`ifdef AES_KEY_EXT_LEN_EN
            err_o <= (state != S_EXPAND) && start_i && (len == KLEN_BAD);
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        nk      <= nk_of(len);
                        nr_o    <= nr_of(len);
                        t_words <= t_of(len);
                        i       <= {2'b00, nk_of(len)};
                        j       <= 3'd0;
                        rcon    <= 8'h01;
                        busy_o  <= 1'b1;
                        done_o  <= 1'b0;
                        state   <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (!stall_i) begin
                        i <= i + 6'd1;
                        j <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
                        if (j == 3'd0)
                            rcon <= xtime(rcon);
                        if (i == t_words - 6'd1) begin
                            state  <= S_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word storage carries no reset; readability comes from i alone.
    always_ff @(posedge clk_i) begin
        if (state != S_EXPAND && start_ok) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_of(len)))
                    w[k] <= key_i[255 - 32*k -: 32];
        end else if (state == S_EXPAND && !stall_i) begin
            w[i] <= new_w;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [3:0]   r;
        logic [5:0]   base;
        logic         hit;
        logic         vld;
        logic [127:0] key;

        assign r    = rd_idx_i[4*p +: 4];
        assign base = {r, 2'b00};
        assign hit  = (r <= nr_o) && (({1'b0, base} + 7'd4) <= {1'b0, i});

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                key <= '0;
            end else begin
                vld <= hit;
                key <= hit ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
            end
        end

        assign rd_valid_o[p]         = vld;
        assign rd_key_o[128*p +: 128] = key;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand against FIPS-197 key-schedule vectors, two read ports.
module tb_aes_key_expand;
    import aes_pkg::*;

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   key_len_i = 2'b00;
    logic [255:0] key_i = '0;
    logic         stall_i = 1'b0;
    logic [7:0]   rd_idx_i = '0;
    logic [255:0] rd_key_o;
    logic [1:0]   rd_valid_o;
    logic         busy_o, done_o, err_o;
    logic [3:0]   nr_o;

    int errors = 0;
    int checks = 0;

    aes_key_expand #(.RD_PORTS(2)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .key_len_i  (key_len_i),
        .key_i      (key_i),
        .stall_i    (stall_i),
        .rd_idx_i   (rd_idx_i),
        .rd_key_o   (rd_key_o),
        .rd_valid_o (rd_valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .nr_o       (nr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_key(input logic [1:0] len, input logic [255:0] key);
        start_i   = 1'b1;
        key_len_i = len;
        key_i     = key;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done_o && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input logic [3:0] idx0, input logic [3:0] idx1);
        rd_idx_i = {idx1, idx0};
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy_o, done_o, err_o, nr_o, rd_valid_o} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/err/nr/vld=%b required 0", {busy_o, done_o, err_o, nr_o, rd_valid_o});
        end
        checks++;
        if (rd_key_o !== 256'd0) begin
            errors++;
            $display("FAIL reset_key: got %h required 0", rd_key_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        rd(4'd0, 4'd1);
        checks++;
        if (rd_valid_o !== 2'b00 || nr_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_noread: got vld=%b nr=%0d required vld=00 nr=0", rd_valid_o, nr_o);
        end
    endtask

    task automatic test_err();
        int n;
`ifdef AES_KEY_EXT_LEN_EN
        start_key(2'b11, K256);
        checks++;
        if ({err_o, busy_o, done_o} !== 3'b100) begin
            errors++;
            $display("FAIL err_pulse: got err/busy/done=%b required 100", {err_o, busy_o, done_o});
        end
        tick();
        checks++;
        if ({err_o, busy_o, done_o, nr_o} !== 7'd0) begin
            errors++;
            $display("FAIL err_clear: got err/busy/done/nr=%b required 0", {err_o, busy_o, done_o, nr_o});
        end
`else
        start_key(2'b11, {K128, 128'd0});
        checks++;
        if ({err_o, busy_o, nr_o} !== {2'b01, 4'd10}) begin
            errors++;
            $display("FAIL len_ignored: got err/busy/nr=%b required 0,1,1010", {err_o, busy_o, nr_o});
        end
        wait_done(n);
        rd(4'd10, 4'd0);
        checks++;
        if (n !== 40 || rd_key_o[127:0] !== R10_128) begin
            errors++;
            $display("FAIL len_ignored_exp: got cycles=%0d r10=%h required 40 %h", n, rd_key_o[127:0], R10_128);
        end
`endif
    endtask

    task automatic test_aes128();
        int n;
        start_key(2'b00, {K128, 128'd0});
        checks++;
        if ({busy_o, done_o, nr_o} !== {2'b10, 4'd10}) begin
            errors++;
            $display("FAIL a128_start: got busy/done/nr=%b required 10,1010", {busy_o, done_o, nr_o});
        end
        rd(4'd0, 4'd1);
        checks++;
        if (rd_valid_o !== 2'b01 || rd_key_o[127:0] !== K128 || rd_key_o[255:128] !== 128'd0) begin
            errors++;
            $display("FAIL a128_early: got vld=%b r0=%h r1=%h required 01 %h 0", rd_valid_o, rd_key_o[127:0], rd_key_o[255:128], K128);
        end
        wait_done(n);
        checks++;
        if (n + 1 !== 40 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL a128_latency: got %0d cycles busy=%b required 40 busy=0", n + 1, busy_o);
        end
        rd(4'd10, 4'd11);
        checks++;
        if (rd_valid_o !== 2'b01 || rd_key_o[127:0] !== R10_128 || rd_key_o[255:128] !== 128'd0) begin
            errors++;
            $display("FAIL a128_r10: got vld=%b r10=%h r11=%h required 01 %h 0", rd_valid_o, rd_key_o[127:0], rd_key_o[255:128], R10_128);
        end
        rd(4'd1, 4'd0);
        checks++;
        if (rd_valid_o !== 2'b11 || rd_key_o[127:0] !== R1_128 || rd_key_o[255:128] !== K128 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL a128_r1: got vld=%b r1=%h r0=%h done=%b required 11 %h %h 1", rd_valid_o, rd_key_o[127:0], rd_key_o[255:128], done_o, R1_128, K128);
        end
    endtask

`ifdef AES_KEY_EXT_LEN_EN
    task automatic test_aes192();
        int n;
        start_key(2'b01, {K192, 64'd0});
        wait_done(n);
        checks++;
        if (n !== 46 || nr_o !== 4'd12) begin
            errors++;
            $display("FAIL a192_latency: got %0d cycles nr=%0d required 46 nr=12", n, nr_o);
        end
        rd(4'd12, 4'd13);
        checks++;
        if (rd_valid_o !== 2'b01 || rd_key_o[127:0] !== R12_192) begin
            errors++;
            $display("FAIL a192_r12: got vld=%b r12=%h required 01 %h", rd_valid_o, rd_key_o[127:0], R12_192);
        end
        rd(4'd0, 4'd0);
        checks++;
        if (rd_key_o[127:0] !== K192[191:64]) begin
            errors++;
            $display("FAIL a192_r0: got %h required %h", rd_key_o[127:0], K192[191:64]);
        end
    endtask

    task automatic test_aes256();
        int n;
        start_key(2'b10, K256);
        rd(4'd0, 4'd1);
        checks++;
        if (rd_valid_o !== 2'b11 || rd_key_o[255:128] !== R1_256) begin
            errors++;
            $display("FAIL a256_early: got vld=%b r1=%h required 11 %h", rd_valid_o, rd_key_o[255:128], R1_256);
        end
        wait_done(n);
        checks++;
        if (n + 1 !== 52 || nr_o !== 4'd14) begin
            errors++;
            $display("FAIL a256_latency: got %0d cycles nr=%0d required 52 nr=14", n + 1, nr_o);
        end
        rd(4'd14, 4'd15);
        checks++;
        if (rd_valid_o !== 2'b01 || rd_key_o[127:0] !== R14_256 || rd_key_o[255:128] !== 128'd0) begin
            errors++;
            $display("FAIL a256_r14: got vld=%b r14=%h r15=%h required 01 %h 0", rd_valid_o, rd_key_o[127:0], rd_key_o[255:128], R14_256);
        end
    endtask
`endif

    task automatic test_stall();
        int n;
        start_key(2'b00, {K128, 128'd0});
        repeat (10) tick();
        stall_i  = 1'b1;
        rd_idx_i = {4'd9, 4'd1};
        tick();
        checks++;
        if (rd_valid_o !== 2'b01 || rd_key_o[127:0] !== R1_128 || rd_key_o[255:128] !== 128'd0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_read: got vld=%b r1=%h r9=%h busy=%b required 01 %h 0 1", rd_valid_o, rd_key_o[127:0], rd_key_o[255:128], busy_o, R1_128);
        end
        repeat (4) tick();
        stall_i = 1'b0;
        wait_done(n);
        checks++;
        if (n + 15 !== 45) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles required 45", n + 15);
        end
        rd(4'd10, 4'd1);
        checks++;
        if (rd_key_o[127:0] !== R10_128 || rd_key_o[255:128] !== R1_128) begin
            errors++;
            $display("FAIL stall_keys: got r10=%h r1=%h required %h %h", rd_key_o[127:0], rd_key_o[255:128], R10_128, R1_128);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        start_key(2'b00, {K128, 128'd0});
        repeat (5) tick();
        start_key(2'b00, 256'd0);
        wait_done(n);
        rd(4'd10, 4'd0);
        checks++;
        if (n + 6 !== 40 || rd_key_o[127:0] !== R10_128 || rd_key_o[255:128] !== K128) begin
            errors++;
            $display("FAIL start_ignored: got cycles=%0d r10=%h r0=%h required 40 %h %h", n + 6, rd_key_o[127:0], rd_key_o[255:128], R10_128, K128);
        end
    endtask

    task automatic test_restart();
        logic [127:0] k2;
        k2 = R10_128;
        start_key(2'b00, {k2, 128'd0});
        rd(4'd0, 4'd10);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1 || rd_valid_o !== 2'b01 || rd_key_o[127:0] !== k2) begin
            errors++;
            $display("FAIL restart: got done=%b busy=%b vld=%b r0=%h required 0 1 01 %h", done_o, busy_o, rd_valid_o, rd_key_o[127:0], k2);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
`ifdef AES_KEY_EXT_LEN_EN
        start_key(2'b10, K256);
`else
        start_key(2'b00, {K128, 128'd0});
`endif
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, nr_o, rd_valid_o} !== 9'd0 || rd_key_o !== 256'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy/done/err/nr/vld=%b key=%h required all 0", {busy_o, done_o, err_o, nr_o, rd_valid_o}, rd_key_o);
        end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            rd(4'(r), 4'(r));
            if (rd_valid_o !== 2'b00 || rd_key_o !== 256'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid_reads: got %0d indices readable required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_err();
        test_aes128();
`ifdef AES_KEY_EXT_LEN_EN
        test_aes192();
        test_aes256();
`endif
        test_stall();
        test_start_ignored();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
